// File: rtl/nvdla_dbb_master_pkg.sv
// Shared types for the DBB master: FSM encoding, packer direction and status flags.
package nvdla_dbb_master_pkg;

    localparam int unsigned HWPE_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_DATA,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        DONE
    } state_dbb_master_fsm_t;

    typedef enum logic {
        PACK,
        UNPACK
    } packer_dir_e;

    typedef struct packed {
        logic done;
        logic err;
        logic busy;
    } flags_dbb_master_t;

endpackage

// File: rtl/nvdla_dbb_word_packer.sv
// 32-bit word <-> RATIO*32-bit beat buffer; PACK gathers words into a beat, UNPACK splits a beat.
module nvdla_dbb_word_packer
    import nvdla_dbb_master_pkg::*;
#(
    parameter int unsigned RATIO = 2,
    parameter packer_dir_e DIR   = PACK,
    localparam int unsigned IN_W  = (DIR == PACK) ? HWPE_W : HWPE_W * RATIO,
    localparam int unsigned OUT_W = (DIR == PACK) ? HWPE_W * RATIO : HWPE_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               en_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [IN_W-1:0]    in_data_i,
    input  logic [IN_W/8-1:0]  in_strb_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [OUT_W-1:0]   out_data_o,
    output logic [OUT_W/8-1:0] out_strb_o,
    output logic               out_last_o
);

    localparam int unsigned CW = $clog2(RATIO);

    logic [RATIO-1:0][HWPE_W-1:0] data_q;
    logic [CW-1:0]                cnt_q;
    logic                         full_q;
    logic                         in_hs, out_hs, last_idx;

    assign in_ready_o  = en_i & ~full_q;
    assign out_valid_o = full_q;
    assign in_hs       = in_valid_i & in_ready_o;
    assign out_hs      = out_valid_o & out_ready_i;
    assign last_idx    = (cnt_q == CW'(RATIO - 1));

    if (DIR == PACK) begin : g_pack
        logic [RATIO-1:0][3:0] strb_q;

        assign out_data_o = data_q;
        assign out_strb_o = strb_q;
        assign out_last_o = last_idx;

        // Word k lands in lane k, so word 0 ends up in the beat LSBs.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_q <= '0;
                strb_q <= '0;
                cnt_q  <= '0;
                full_q <= 1'b0;
            end else if (clear_i || out_hs) begin
                data_q <= '0;
                strb_q <= '0;
                cnt_q  <= '0;
                full_q <= 1'b0;
            end else if (in_hs) begin
                data_q[cnt_q] <= in_data_i;
                strb_q[cnt_q] <= in_strb_i;
                if (last_idx) begin
                    cnt_q  <= '0;
                    full_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end else begin : g_unpack
        logic strb_unused;

        assign strb_unused = ^in_strb_i;
        assign out_data_o  = data_q[cnt_q];
        assign out_strb_o  = {(OUT_W/8){full_q}};
        assign out_last_o  = last_idx;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_q <= '0;
                cnt_q  <= '0;
                full_q <= 1'b0;
            end else if (clear_i) begin
                data_q <= '0;
                cnt_q  <= '0;
                full_q <= 1'b0;
            end else if (in_hs) begin
                data_q <= in_data_i;
                cnt_q  <= '0;
                full_q <= 1'b1;
            end else if (out_hs) begin
                if (last_idx) begin
                    cnt_q  <= '0;
                    full_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/nvdla_dbb_master.sv
// DBB initiator: turns one command into a DBB read or write burst, bridging 32-bit HWPE streams.
module nvdla_dbb_master
    import nvdla_dbb_master_pkg::*;
#(
    parameter int unsigned MEMIF_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned ID_WIDTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]     cmd_len_i,
    input  logic [ID_WIDTH-1:0]      cmd_id_i,
    output logic                     done_o,
    output logic                     err_o,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [31:0]              wr_data_i,
    input  logic [3:0]               wr_strb_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [31:0]              rd_data_o,
    output logic [3:0]               rd_strb_o,
    output logic                     wr_req_valid_o,
    input  logic                     wr_req_ready_i,
    output logic [ADDR_WIDTH-1:0]    wr_req_addr_o,
    output logic [LEN_WIDTH-1:0]     wr_req_len_o,
    output logic [ID_WIDTH-1:0]      wr_req_id_o,
    output logic                     wr_dat_valid_o,
    input  logic                     wr_dat_ready_i,
    output logic [MEMIF_WIDTH-1:0]   wr_dat_data_o,
    output logic [MEMIF_WIDTH/8-1:0] wr_dat_strb_o,
    output logic                     wr_dat_last_o,
    input  logic                     wr_rsp_valid_i,
    output logic                     wr_rsp_ready_o,
    input  logic [ID_WIDTH-1:0]      wr_rsp_id_i,
    output logic                     rd_req_valid_o,
    input  logic                     rd_req_ready_i,
    output logic [ADDR_WIDTH-1:0]    rd_req_addr_o,
    output logic [LEN_WIDTH-1:0]     rd_req_len_o,
    output logic [ID_WIDTH-1:0]      rd_req_id_o,
    input  logic                     rd_dat_valid_i,
    output logic                     rd_dat_ready_o,
    input  logic [MEMIF_WIDTH-1:0]   rd_dat_data_i,
    input  logic                     rd_dat_last_i,
    input  logic [ID_WIDTH-1:0]      rd_dat_id_i
);

    localparam int unsigned RATIO = MEMIF_WIDTH / 32;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic [ID_WIDTH-1:0]   id;
    } ctrl_dbb_master_t;

    state_dbb_master_fsm_t state_q, state_d;
    ctrl_dbb_master_t      ctrl_q, ctrl_d;
    flags_dbb_master_t     flags_q, flags_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic                  err_q, err_d;
    logic                  req_valid, last_beat, rd_last_word, pk_last_unused;
    logic                  wr_dat_hs, rd_dat_hs, rd_word_hs;

    nvdla_dbb_word_packer #(.RATIO(RATIO), .DIR(PACK)) i_pack (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .en_i        (state_q == WR_DATA),
        .in_valid_i  (wr_valid_i),
        .in_ready_o  (wr_ready_o),
        .in_data_i   (wr_data_i),
        .in_strb_i   (wr_strb_i),
        .out_valid_o (wr_dat_valid_o),
        .out_ready_i (wr_dat_ready_i),
        .out_data_o  (wr_dat_data_o),
        .out_strb_o  (wr_dat_strb_o),
        .out_last_o  (pk_last_unused)
    );

    nvdla_dbb_word_packer #(.RATIO(RATIO), .DIR(UNPACK)) i_unpack (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .en_i        (state_q == RD_DATA),
        .in_valid_i  (rd_dat_valid_i),
        .in_ready_o  (rd_dat_ready_o),
        .in_data_i   (rd_dat_data_i),
        .in_strb_i   ('1),
        .out_valid_o (rd_valid_o),
        .out_ready_i (rd_ready_i),
        .out_data_o  (rd_data_o),
        .out_strb_o  (rd_strb_o),
        .out_last_o  (rd_last_word)
    );

    assign wr_dat_hs  = wr_dat_valid_o & wr_dat_ready_i;
    assign rd_dat_hs  = rd_dat_valid_i & rd_dat_ready_o;
    assign rd_word_hs = rd_valid_o & rd_ready_i;
    assign last_beat  = (beat_q == ctrl_q.len - LEN_WIDTH'(1));

    assign req_valid      = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign wr_req_valid_o = req_valid & ctrl_q.write;
    assign rd_req_valid_o = req_valid & ~ctrl_q.write;
    assign wr_req_addr_o  = ctrl_q.addr;
    assign wr_req_len_o   = ctrl_q.len;
    assign wr_req_id_o    = ctrl_q.id;
    assign rd_req_addr_o  = ctrl_q.addr;
    assign rd_req_len_o   = ctrl_q.len;
    assign rd_req_id_o    = ctrl_q.id;
    assign wr_dat_last_o  = wr_dat_valid_o & last_beat;
    assign wr_rsp_ready_o = (state_q == WR_RESP);
    assign cmd_ready_o    = ~flags_q.busy;
    assign done_o         = flags_q.done;
    assign err_o          = flags_q.err;

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        beat_d  = beat_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (cmd_valid_i) begin
                ctrl_d = '{write: cmd_write_i, addr: cmd_addr_i, len: cmd_len_i, id: cmd_id_i};
                beat_d = '0;
                err_d  = 1'b0;
                if (cmd_len_i == '0) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = cmd_write_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: if (wr_req_ready_i) state_d = WR_DATA;
            WR_DATA: if (wr_dat_hs) begin
                beat_d = beat_q + LEN_WIDTH'(1);
                if (last_beat) state_d = WR_RESP;
            end
            WR_RESP: if (wr_rsp_valid_i) begin
                if (wr_rsp_id_i != ctrl_q.id) err_d = 1'b1;
                state_d = DONE;
            end
            RD_REQ: if (rd_req_ready_i) state_d = RD_DATA;
            RD_DATA: begin
                // Early or missing last only flags an error; the burst length stays authoritative.
                if (rd_dat_hs) begin
                    beat_d = beat_q + LEN_WIDTH'(1);
                    if (rd_dat_id_i != ctrl_q.id || rd_dat_last_i != last_beat) err_d = 1'b1;
                end
                if (rd_word_hs && rd_last_word && beat_q == ctrl_q.len) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        flags_d.busy = (state_d != IDLE);
        flags_d.done = (state_q == DONE);
        flags_d.err  = (state_q == DONE) & err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            flags_q <= '0;
        end else if (clear_i) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_nvdla_dbb_master.sv
// Directed plus randomized bench for nvdla_dbb_master (MEMIF_WIDTH=64) with a queue-based reference.
module tb_nvdla_dbb_master;

    logic        clk_i = 0, rst_ni = 0, clear_i = 0;
    logic        cmd_valid_i = 0, cmd_ready_o, cmd_write_i = 0;
    logic [63:0] cmd_addr_i = 0;
    logic [7:0]  cmd_len_i = 0, cmd_id_i = 0;
    logic        done_o, err_o;
    logic        wr_valid_i = 0, wr_ready_o;
    logic [31:0] wr_data_i = 0;
    logic [3:0]  wr_strb_i = 0;
    logic        rd_valid_o, rd_ready_i = 0;
    logic [31:0] rd_data_o;
    logic [3:0]  rd_strb_o;
    logic        wr_req_valid_o, wr_req_ready_i = 0;
    logic [63:0] wr_req_addr_o;
    logic [7:0]  wr_req_len_o, wr_req_id_o;
    logic        wr_dat_valid_o, wr_dat_ready_i = 0, wr_dat_last_o;
    logic [63:0] wr_dat_data_o;
    logic [7:0]  wr_dat_strb_o;
    logic        wr_rsp_valid_i = 0, wr_rsp_ready_o;
    logic [7:0]  wr_rsp_id_i = 0;
    logic        rd_req_valid_o, rd_req_ready_i = 0;
    logic [63:0] rd_req_addr_o;
    logic [7:0]  rd_req_len_o, rd_req_id_o;
    logic        rd_dat_valid_i = 0, rd_dat_ready_o, rd_dat_last_i = 0;
    logic [63:0] rd_dat_data_i = 0;
    logic [7:0]  rd_dat_id_i = 0;

    nvdla_dbb_master dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_id_i(cmd_id_i),
        .done_o(done_o), .err_o(err_o),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .rd_strb_o(rd_strb_o),
        .wr_req_valid_o(wr_req_valid_o), .wr_req_ready_i(wr_req_ready_i), .wr_req_addr_o(wr_req_addr_o),
        .wr_req_len_o(wr_req_len_o), .wr_req_id_o(wr_req_id_o),
        .wr_dat_valid_o(wr_dat_valid_o), .wr_dat_ready_i(wr_dat_ready_i), .wr_dat_data_o(wr_dat_data_o),
        .wr_dat_strb_o(wr_dat_strb_o), .wr_dat_last_o(wr_dat_last_o),
        .wr_rsp_valid_i(wr_rsp_valid_i), .wr_rsp_ready_o(wr_rsp_ready_o), .wr_rsp_id_i(wr_rsp_id_i),
        .rd_req_valid_o(rd_req_valid_o), .rd_req_ready_i(rd_req_ready_i), .rd_req_addr_o(rd_req_addr_o),
        .rd_req_len_o(rd_req_len_o), .rd_req_id_o(rd_req_id_o),
        .rd_dat_valid_i(rd_dat_valid_i), .rd_dat_ready_o(rd_dat_ready_o), .rd_dat_data_i(rd_dat_data_i),
        .rd_dat_last_i(rd_dat_last_i), .rd_dat_id_i(rd_dat_id_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;
    logic [31:0] wwords[$];
    logic [3:0]  wstrb[$];
    logic [63:0] rbeats[$];
    bit          rlast[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit rnd(input bit fast);
        return fast ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    // Write burst; payload comes from wwords/wstrb (2 words per 64-bit beat).
    task automatic run_write(input logic [63:0] addr, input logic [7:0] len, input logic [7:0] id,
                             input logic [7:0] rsp_id, input int bp, input bit fast);
        logic [63:0] exp_beat[$];
        logic [7:0]  exp_bstrb[$];
        int widx, bidx, it;
        bit req_done, rsp_done, seen, exp_err;
        widx = 0; bidx = 0; it = 0; req_done = 0; rsp_done = 0; seen = 0;
        exp_err = (rsp_id != id);
        for (int j = 0; j < len; j++) begin
            exp_beat.push_back({wwords[2*j+1], wwords[2*j]});
            exp_bstrb.push_back({wstrb[2*j+1], wstrb[2*j]});
        end
        @(negedge clk_i);
        chk("wr_cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1; cmd_write_i = 1; cmd_addr_i = addr; cmd_len_i = len; cmd_id_i = id;
        while (!seen && it < 400) begin
            @(negedge clk_i);
            cmd_valid_i = 0;
            it++;
            if (!req_done) chk("wr_ready_before_req", wr_ready_o, 0);
            if (bidx < len) chk("wr_rsp_ready_early", wr_rsp_ready_o, 0);
            if (wr_req_valid_o) begin
                chk("wr_req_addr", wr_req_addr_o, addr);
                chk("wr_req_len", wr_req_len_o, len);
                chk("wr_req_id", wr_req_id_o, id);
                chk("wr_req_repeat", req_done, 0);
            end
            wr_req_ready_i = (it <= bp) ? 1'b0 : rnd(fast);
            if (wr_req_valid_o && wr_req_ready_i) req_done = 1;
            wr_valid_i = (widx < 2 * len);
            wr_data_i  = wr_valid_i ? wwords[widx] : 32'h0;
            wr_strb_i  = wr_valid_i ? wstrb[widx] : 4'h0;
            if (wr_valid_i && wr_ready_o) widx++;
            if (wr_dat_valid_o) begin
                chk("wr_dat_extra", bidx < len, 1);
                if (bidx < len) begin
                    chk("wr_dat_data", wr_dat_data_o, exp_beat[bidx]);
                    chk("wr_dat_strb", wr_dat_strb_o, exp_bstrb[bidx]);
                    chk("wr_dat_last", wr_dat_last_o, bidx == len - 1);
                end
            end
            wr_dat_ready_i = (it <= bp) ? 1'b0 : rnd(fast);
            if (wr_dat_valid_o && wr_dat_ready_i) bidx++;
            wr_rsp_valid_i = !rsp_done;
            wr_rsp_id_i = rsp_id;
            if (wr_rsp_ready_o && wr_rsp_valid_i) rsp_done = 1;
            if (done_o) begin
                seen = 1;
                chk("wr_done_beats", bidx, len);
                chk("wr_done_rsp", rsp_done, 1);
                chk("wr_err", err_o, exp_err);
                if (fast) chk("wr_min_latency", it >= 6, 1);
            end
        end
        if (!seen) chk("wr_timeout", 0, 1);
        wr_valid_i = 0; wr_rsp_valid_i = 0; wr_req_ready_i = 0; wr_dat_ready_i = 0;
        @(negedge clk_i);
        chk("wr_done_pulse", done_o, 0);
        chk("wr_idle_ready", cmd_ready_o, 1);
    endtask

    // Read burst; beats come from rbeats/rlast, bid is driven on rd_dat_id_i.
    task automatic run_read(input logic [63:0] addr, input logic [7:0] len, input logic [7:0] id,
                            input logic [7:0] bid, input bit fast);
        logic [31:0] exp_w[$];
        int bi, k, it, first;
        bit req_done, seen, exp_err;
        bi = 0; k = 0; it = 0; first = -1; req_done = 0; seen = 0;
        exp_err = (bid != id);
        for (int j = 0; j < len; j++) begin
            exp_w.push_back(rbeats[j][31:0]);
            exp_w.push_back(rbeats[j][63:32]);
            if (rlast[j] != (j == len - 1)) exp_err = 1;
        end
        @(negedge clk_i);
        chk("rd_cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1; cmd_write_i = 0; cmd_addr_i = addr; cmd_len_i = len; cmd_id_i = id;
        while (!seen && it < 400) begin
            @(negedge clk_i);
            cmd_valid_i = 0;
            it++;
            if (!req_done) chk("rd_dat_ready_before_req", rd_dat_ready_o, 0);
            chk("rd_no_wr_req", wr_req_valid_o, 0);
            if (rd_req_valid_o) begin
                chk("rd_req_addr", rd_req_addr_o, addr);
                chk("rd_req_len", rd_req_len_o, len);
                chk("rd_req_id", rd_req_id_o, id);
            end
            rd_req_ready_i = rnd(fast);
            if (rd_req_valid_o && rd_req_ready_i) req_done = 1;
            rd_dat_valid_i = (bi < len);
            rd_dat_data_i  = rd_dat_valid_i ? rbeats[bi] : 64'h0;
            rd_dat_last_i  = rd_dat_valid_i ? rlast[bi] : 1'b0;
            rd_dat_id_i    = bid;
            if (rd_dat_valid_i && rd_dat_ready_o) bi++;
            if (rd_valid_o) begin
                if (first < 0) first = it;
                chk("rd_word_extra", k < 2 * len, 1);
                if (k < 2 * len) chk("rd_word", rd_data_o, exp_w[k]);
                chk("rd_strb", rd_strb_o, 4'hF);
            end
            rd_ready_i = rnd(fast);
            if (rd_valid_o && rd_ready_i) k++;
            if (done_o) begin
                seen = 1;
                chk("rd_done_words", k, 2 * len);
                chk("rd_done_beats", bi, len);
                chk("rd_err", err_o, exp_err);
                if (fast) chk("rd_first_latency", first, 3);
            end
        end
        if (!seen) chk("rd_timeout", 0, 1);
        rd_dat_valid_i = 0; rd_req_ready_i = 0; rd_ready_i = 0;
        @(negedge clk_i);
        chk("rd_done_pulse", done_o, 0);
        chk("rd_idle_ready", cmd_ready_o, 1);
    endtask

    task automatic fill_write(input int len, input bit rand_strb);
        wwords = {}; wstrb = {};
        for (int i = 0; i < 2 * len; i++) begin
            wwords.push_back($urandom);
            wstrb.push_back(rand_strb ? 4'($urandom_range(0, 15)) : 4'hF);
        end
    endtask

    // Start a write, push one word, then abort it by clear or reset.
    task automatic abort_write(input bit use_rst);
        @(negedge clk_i);
        cmd_valid_i = 1; cmd_write_i = 1; cmd_addr_i = 64'h40; cmd_len_i = 2; cmd_id_i = 1;
        @(negedge clk_i);
        cmd_valid_i = 0; wr_req_ready_i = 1;
        @(negedge clk_i);
        wr_req_ready_i = 0; wr_valid_i = 1; wr_data_i = 32'hDEAD0001; wr_strb_i = 4'hF;
        chk("abort_wr_ready", wr_ready_o, 1);
        @(negedge clk_i);
        wr_valid_i = 0;
        if (use_rst) begin
            rst_ni = 0;
            #1 chk("abort_rst_idle", cmd_ready_o, 1);
        end else clear_i = 1;
        @(negedge clk_i);
        clear_i = 0; rst_ni = 1;
        chk("abort_idle", cmd_ready_o, 1);
        chk("abort_no_done", done_o, 0);
        chk("abort_no_wdat", wr_dat_valid_o, 0);
        chk("abort_addr_zero", wr_req_addr_o, 0);
        @(negedge clk_i);
        chk("abort_no_done2", done_o, 0);
    endtask

    initial begin
        logic [7:0] id, len;
        #1;
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_wr_req_valid", wr_req_valid_o, 0);
        chk("rst_rd_req_valid", rd_req_valid_o, 0);
        chk("rst_wr_dat_valid", wr_dat_valid_o, 0);
        chk("rst_wr_dat_data", wr_dat_data_o, 0);
        chk("rst_wr_dat_strb", wr_dat_strb_o, 0);
        chk("rst_wr_dat_last", wr_dat_last_o, 0);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_rd_strb", rd_strb_o, 0);
        chk("rst_rd_dat_ready", rd_dat_ready_o, 0);
        chk("rst_wr_ready", wr_ready_o, 0);
        chk("rst_wr_rsp_ready", wr_rsp_ready_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_addr", wr_req_addr_o, 0);
        @(negedge clk_i) rst_ni = 1;

        wwords = {32'h11, 32'h22, 32'h33, 32'h44};
        wstrb  = {4'hF, 4'hF, 4'hF, 4'hF};
        run_write(64'h1000, 2, 5, 5, 0, 0);

        rbeats = {64'h0000000B_0000000A, 64'h0000000D_0000000C, 64'h0000000F_0000000E};
        rlast  = {1'b0, 1'b0, 1'b1};
        run_read(64'h2000, 3, 7, 7, 0);

        fill_write(2, 0);
        run_write(64'h3000, 2, 9, 9, 10, 0);

        fill_write(2, 0);
        run_write(64'h1000, 2, 5, 6, 0, 0);

        rbeats = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        rlast  = {1'b1, 1'b1};
        run_read(64'h4000, 2, 3, 3, 0);

        // len=0 command: error completion, no DBB traffic
        @(negedge clk_i);
        cmd_valid_i = 1; cmd_write_i = 1; cmd_len_i = 0; cmd_id_i = 3; cmd_addr_i = 64'h80;
        @(negedge clk_i);
        cmd_valid_i = 0;
        chk("len0_done_early", done_o, 0);
        chk("len0_no_wr_req", wr_req_valid_o, 0);
        chk("len0_no_rd_req", rd_req_valid_o, 0);
        @(negedge clk_i);
        chk("len0_done", done_o, 1);
        chk("len0_err", err_o, 1);
        chk("len0_no_wr_req2", wr_req_valid_o, 0);
        @(negedge clk_i);
        chk("len0_done_pulse", done_o, 0);
        chk("len0_err_pulse", err_o, 0);

        fill_write(1, 0);
        run_write(64'h5000, 1, 2, 2, 0, 1);
        rbeats = {{$urandom, $urandom}};
        rlast  = {1'b1};
        run_read(64'h6000, 1, 4, 4, 1);

        abort_write(0);
        fill_write(2, 0);
        run_write(64'h7000, 2, 8, 8, 0, 0);
        abort_write(1);
        fill_write(2, 0);
        run_write(64'h7100, 2, 8, 8, 0, 0);

        for (int t = 0; t < 6; t++) begin
            len = 8'($urandom_range(1, 4));
            id  = 8'($urandom);
            fill_write(len, 1);
            run_write({$urandom, $urandom}, len, id, ($urandom_range(0, 3) == 0) ? id ^ 8'h1 : id, 0, 0);
            len = 8'($urandom_range(1, 4));
            id  = 8'($urandom);
            rbeats = {}; rlast = {};
            for (int j = 0; j < len; j++) begin
                rbeats.push_back({$urandom, $urandom});
                rlast.push_back((j == len - 1) ^ ($urandom_range(0, 7) == 0));
            end
            run_read({$urandom, $urandom}, len, id, ($urandom_range(0, 5) == 0) ? id + 8'h1 : id, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
